// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB write master.
package sccb_pkg;

  typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} sccb_state_t;
  typedef logic [1:0] sccb_phase_t;

  localparam int SCCB_BITS_PER_PHASE = 9;
  localparam int SCCB_PHASES = 3;

  // The quarter index runs on from the accept, so START covers raw indices 0,1 and every
  // later 4-quarter slot (bit or STOP) begins at raw index 2; this yields the slot quarter.
  function automatic logic [1:0] slot_quarter(input logic [1:0] qidx);
    return qidx ^ 2'b10;
  endfunction

endpackage

// File: rtl/sccb_write_master_if.sv
// Request handshake plus SCCB pad signals between the init sequencer and the write master.
interface sccb_write_master_if;

  logic       start;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       busy;
  logic       done;
  logic       scl;
  logic       sda;
  logic       sda_oe;

  modport master (
    input  start, reg_addr, reg_data,
    output busy, done, scl, sda, sda_oe
  );

  modport slave (
    output start, reg_addr, reg_data,
    input  busy, done, scl, sda, sda_oe
  );

endinterface

// File: rtl/sccb_qtr_tick.sv
// Quarter-bit timebase: one-cycle tick every QTR cycles and a free-running 2-bit quarter index.
module sccb_qtr_tick #(
  parameter int QTR = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       tick,
  output logic [1:0] qidx
);

  localparam int CW = $clog2(QTR);
  localparam logic [CW-1:0] LAST = CW'(QTR - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt  <= '0;
      qidx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        qidx <= qidx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: START, DEV_ADDR, reg_addr, reg_data (9 bits each), STOP, done pulse.
module sccb_write_master
  import sccb_pkg::*;
#(
  parameter int          CLK_HZ   = 50_000_000,
  parameter int          SCL_HZ   = 100_000,
  parameter logic [7:0]  DEV_ADDR = 8'h42
) (
  input  logic                clk,
  input  logic                reset,
  sccb_write_master_if.master bus
);

  localparam int QTR = CLK_HZ / (4 * SCL_HZ);

  sccb_state_t state, state_next;
  sccb_phase_t phase_idx;
  logic [3:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  addr_q;
  logic [7:0]  data_q;
  logic        tick;
  logic [1:0]  qidx;
  logic [1:0]  sq;
  logic        run;
  logic        step_end;
  logic        last_bit;
  logic        last_phase;
  logic        scl_c;
  logic        sda_c;
  logic        oe_c;

  assign run        = (state == START) || (state == BIT) || (state == STOP);
  assign sq         = slot_quarter(qidx);
  assign step_end   = tick && (qidx == 2'd1);
  assign last_bit   = (bit_idx == 4'(SCCB_BITS_PER_PHASE - 1));
  assign last_phase = (phase_idx == 2'(SCCB_PHASES - 1));

  sccb_qtr_tick #(.QTR(QTR)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick),
    .qidx  (qidx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = START;
      START:   if (step_end) state_next = BIT;
      BIT:     if (step_end && last_bit && last_phase) state_next = STOP;
      STOP:    if (step_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus levels are a pure decode of state and slot quarter; the released ninth bit reads as 1.
  always_comb begin
    scl_c = 1'b1;
    sda_c = 1'b1;
    oe_c  = 1'b1;
    unique case (state)
      START: begin
        scl_c = (qidx == 2'd0);
        sda_c = 1'b0;
      end
      BIT: begin
        scl_c = sq[1];
        if (last_bit) begin
          oe_c = 1'b0;
        end else begin
          sda_c = shreg[7];
        end
      end
      STOP: begin
        scl_c = (sq != 2'd0);
        sda_c = sq[1];
      end
      default: ;
    endcase
  end

  assign bus.scl    = scl_c;
  assign bus.sda    = sda_c;
  assign bus.sda_oe = oe_c;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      data_q    <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      phase_idx <= '0;
    end else if (state == IDLE && bus.start) begin
      addr_q    <= bus.reg_addr;
      data_q    <= bus.reg_data;
      shreg     <= DEV_ADDR;
      bit_idx   <= '0;
      phase_idx <= '0;
    end else if (state == BIT && step_end) begin
      if (last_bit) begin
        bit_idx <= '0;
        if (!last_phase) begin
          phase_idx <= phase_idx + 1'b1;
          shreg     <= (phase_idx == 2'd0) ? addr_q : data_q;
        end
      end else begin
        bit_idx <= bit_idx + 1'b1;
        shreg   <= {shreg[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_sccb_write_master.sv
// Self-checking bench: per-cycle compare against a quarter-level bus model plus an SCCB slave monitor.
module tb_sccb_write_master;

  localparam int QTR  = 4;
  localparam int LAST = 114 * QTR + 1;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  sccb_write_master_if bus_if ();

  sccb_write_master #(
    .CLK_HZ   (1_600_000),
    .SCL_HZ   (100_000),
    .DEV_ADDR (8'h42)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus_if.busy, bus_if.done, bus_if.scl, bus_if.sda, bus_if.sda_oe};
  endfunction

  // Expected {scl, sda, sda_oe} for quarter q of a transfer, straight from the waveform tables.
  function automatic logic [2:0] exp_bus(input int q, input logic [7:0] a, input logic [7:0] d);
    int b, j, ph, bt;
    logic [7:0] by;
    if (q < 2) return {(q == 0), 1'b0, 1'b1};
    if (q < 2 + 27 * 4) begin
      b  = (q - 2) / 4;
      j  = (q - 2) % 4;
      ph = b / 9;
      bt = b % 9;
      by = (ph == 0) ? 8'h42 : ((ph == 1) ? a : d);
      if (bt == 8) return {(j >= 2), 1'b1, 1'b0};
      return {(j >= 2), by[7 - bt], 1'b1};
    end
    j = q - 110;
    return {(j != 0), (j >= 2), 1'b1};
  endfunction

  int         m_k;
  logic [7:0] m_addr;
  logic [7:0] m_data;
  logic [4:0] m_exp;

  // m_k counts cycles since the accepted start (1 = first START cycle, LAST = done cycle).
  always @(posedge clk) begin
    if (reset) begin
      m_k <= 0;
    end else if (m_k == 0) begin
      if (bus_if.start) begin
        m_k    <= 1;
        m_addr <= bus_if.reg_addr;
        m_data <= bus_if.reg_data;
      end
    end else if (m_k == LAST) begin
      m_k <= 0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (m_k == 0)         m_exp = 5'b00111;
    else if (m_k == LAST) m_exp = 5'b11111;
    else                  m_exp = {2'b10, exp_bus((m_k - 1) / QTR, m_addr, m_data)};
    check_val("cycle_out", outs(), m_exp);
  end

  logic [7:0] mon_bytes[$];
  logic [8:0] mon_sh;
  int         mon_bits, mon_starts, mon_stops, mon_rises, mon_dones, dones_total;
  logic       prev_scl, prev_sda;
  logic       sda_e;

  always begin
    @(posedge clk);
    #2;
    sda_e = bus_if.sda_oe ? bus_if.sda : 1'b1;
    if (!reset) begin
      if (bus_if.scl && prev_scl && prev_sda && !sda_e) begin
        mon_starts++;
        mon_bits = 0;
      end
      if (bus_if.scl && prev_scl && !prev_sda && sda_e) mon_stops++;
      if (!prev_scl && bus_if.scl) begin
        mon_rises++;
        mon_sh = {mon_sh[7:0], sda_e};
        mon_bits++;
        if (mon_bits == 9) begin
          mon_bytes.push_back(mon_sh[8:1]);
          mon_bits = 0;
        end
      end
      if (bus_if.done) begin
        mon_dones++;
        dones_total++;
      end
    end
    prev_scl = bus_if.scl;
    prev_sda = sda_e;
  end

  task automatic clear_monitor();
    mon_bytes.delete();
    mon_bits   = 0;
    mon_starts = 0;
    mon_stops  = 0;
    mon_rises  = 0;
    mon_dones  = 0;
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] d, output int t_acc);
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.reg_addr = a;
    bus_if.reg_data = d;
    @(negedge clk);
    bus_if.start = 1'b0;
    t_acc = cyc;
    check_val("busy_after_accept", bus_if.busy, 1'b1);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus_if.done !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  // 27 data clocks plus the rising edge inside STOP give 28 scl rises per transfer.
  task automatic check_transfer(input logic [7:0] a, input logic [7:0] d);
    check_val("byte_count", mon_bytes.size(), 3);
    if (mon_bytes.size() == 3) begin
      check_val("byte_dev", mon_bytes[0], 8'h42);
      check_val("byte_reg", mon_bytes[1], a);
      check_val("byte_val", mon_bytes[2], d);
    end
    check_val("start_count", mon_starts, 1);
    check_val("stop_count", mon_stops, 1);
    check_val("scl_rises", mon_rises, 28);
    check_val("done_count", mon_dones, 1);
  endtask

  int         t0;
  int         d_before;
  int         pin_k[9]   = '{1, 5, 9, 33, 145, 209, 445, 457, 458};
  logic [4:0] pin_exp[9] = '{5'b10101, 5'b10001, 5'b10001, 5'b10111, 5'b10110,
                             5'b10111, 5'b10101, 5'b11111, 5'b00111};
  logic [7:0] ra, rd;

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    dones_total = 0;
    prev_scl = 1'b1;
    prev_sda = 1'b1;
    mon_sh = '0;
    clear_monitor();
    reset = 1'b1;
    bus_if.start = 1'b0;
    bus_if.reg_addr = '0;
    bus_if.reg_data = '0;

    repeat (3) @(negedge clk);
    check_val("reset_state", outs(), 5'b00111);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single write 12/80");
    clear_monitor();
    do_start(8'h12, 8'h80, t0);
    for (int i = 0; i < 9; i++) begin
      wait_until(t0 + pin_k[i] - 1);
      check_val($sformatf("pin_k%0d", pin_k[i]), outs(), pin_exp[i]);
    end
    check_transfer(8'h12, 8'h80);

    $display("[TB] start while busy");
    repeat (3) @(negedge clk);
    clear_monitor();
    d_before = dones_total;
    do_start(8'h12, 8'h80, t0);
    wait_until(t0 + 99);
    bus_if.start    = 1'b1;
    bus_if.reg_addr = 8'h3A;
    bus_if.reg_data = 8'h04;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_done();
    check_val("done_cycle", cyc - t0, 456);
    check_transfer(8'h12, 8'h80);

    $display("[TB] back-to-back 11/01");
    clear_monitor();
    do_start(8'h11, 8'h01, t0);
    wait_done();
    check_transfer(8'h11, 8'h01);
    check_val("two_dones", dones_total - d_before, 2);

    $display("[TB] mid-transfer reset");
    repeat (2) @(negedge clk);
    clear_monitor();
    do_start(8'h55, 8'hAA, t0);
    wait_until(t0 + 199);
    reset = 1'b1;
    @(negedge clk);
    check_val("reset_abort", outs(), 5'b00111);
    reset = 1'b0;
    repeat (500) @(negedge clk);
    check_val("no_done_after_abort", mon_dones, 0);
    clear_monitor();
    do_start(8'h6B, 8'hC3, t0);
    wait_done();
    check_transfer(8'h6B, 8'hC3);

    $display("[TB] random writes");
    for (int n = 0; n < 5; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      ra = 8'($urandom);
      rd = 8'($urandom);
      clear_monitor();
      do_start(ra, rd, t0);
      wait_done();
      check_transfer(ra, rd);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
